ddr3_dq_sched: RTL



---
 rtl/ddr3_sched_pkg.sv | 26 ++
 rtl/ddr3_sr36.sv | 24 ++
 rtl/ddr3_dq_sched.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/ddr3_sched_pkg.sv
// Shared types and constants for the DDR3 data-phase scheduler and its delay line.
package ddr3_sched_pkg;

  localparam int TAG_W     = 34;
  localparam int PW        = 36;
  localparam int VALID_BIT = 35;
  localparam int WR_BIT    = 34;

  typedef enum logic {
    ST_FLUSH = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  typedef enum logic {
    DIR_RD = 1'b0,
    DIR_WR = 1'b1
  } dir_e;

  // Field order matches VALID_BIT / WR_BIT: {valid, wr, tag}.
  typedef struct packed {
    logic             valid;
    logic             wr;
    logic [TAG_W-1:0] tag;
  } pipe_word_t;

endpackage

// File: rtl/ddr3_sr36.sv
// Fixed-length 36-bit delay line: a word presented at cycle t appears at cycle t+PIPE_LEN.
module ddr3_sr36
  import ddr3_sched_pkg::*;
#(
  parameter int PIPE_LEN = 7
) (
  input  logic          clk,
  input  logic [PW-1:0] shift_in,
  output logic [PW-1:0] shift_out
);

  logic [PW-1:0] stage_q [PIPE_LEN];

  // NOTE: the stages carry no reset; the owner flushes them by shifting in zero words.
  always_ff @(posedge clk) begin
    stage_q[0] <= shift_in;
    for (int i = 1; i < PIPE_LEN; i++) begin
      stage_q[i] <= stage_q[i-1];
    end
  end

  assign shift_out = stage_q[PIPE_LEN-1];

endmodule

// File: rtl/ddr3_dq_sched.sv
// DDR3 data-bus phase scheduler: read/write arbitration with tCCD and turnaround spacing.
// Optional grant statistics are compiled in with DDR3_DQ_SCHED_STATS_EN.
module ddr3_dq_sched
  import ddr3_sched_pkg::*;
#(
  parameter int PIPE_LEN = 7,
  parameter int TCCD     = 4,
  parameter int TTURN    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_valid,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             rd_ready,
  input  logic             wr_valid,
  input  logic [TAG_W-1:0] wr_tag,
  output logic             wr_ready,
  output logic             dp_valid,
  output logic             dp_wr,
  output logic [TAG_W-1:0] dp_tag,
  output logic             busy
`ifdef DDR3_DQ_SCHED_STATS_EN
  ,
  output logic [15:0]      stat_rd,
  output logic [15:0]      stat_wr,
  output logic [15:0]      stat_turn
`endif
);

  localparam int SINCE_W  = $clog2(TTURN + 1);
  localparam int FLUSH_W  = $clog2(PIPE_LEN + 1);
  localparam int INFL_MAX = (PIPE_LEN + TCCD - 1) / TCCD + 1;
  localparam int INFL_W   = $clog2(INFL_MAX + 1);
  localparam logic [SINCE_W-1:0] TCCD_C  = SINCE_W'(TCCD);
  localparam logic [SINCE_W-1:0] TTURN_C = SINCE_W'(TTURN);

  state_e             state_q, state_d;
  logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [SINCE_W-1:0] since_q, since_d;
  dir_e               last_dir_q, last_dir_d;
  dir_e               rr_pref_q, rr_pref_d;
  logic [INFL_W-1:0]  inflight_q, inflight_d;
  logic               running, rd_ok, wr_ok, grant;
  dir_e               gnt_dir;
  pipe_word_t         word_in, word_out;

  // Grants are suppressed during rst even if the state register still reads RUN.
  assign running  = (state_q == ST_RUN) && !rst;
  assign rd_ok    = running && rd_valid &&
                    (since_q >= ((last_dir_q == DIR_RD) ? TCCD_C : TTURN_C));
  assign wr_ok    = running && wr_valid &&
                    (since_q >= ((last_dir_q == DIR_WR) ? TCCD_C : TTURN_C));
  assign rd_ready = rd_ok && !(wr_ok && (rr_pref_q == DIR_WR));
  assign wr_ready = wr_ok && !(rd_ok && (rr_pref_q == DIR_RD));
  assign grant    = rd_ready || wr_ready;
  assign gnt_dir  = wr_ready ? DIR_WR : DIR_RD;

  always_comb begin
    word_in = '0;
    if (grant) begin
      word_in.valid = 1'b1;
      word_in.wr    = wr_ready;
      word_in.tag   = wr_ready ? wr_tag : rd_tag;
    end
  end

  ddr3_sr36 #(.PIPE_LEN(PIPE_LEN)) u_dly (
    .clk       (clk),
    .shift_in  (word_in),
    .shift_out (word_out)
  );

  assign dp_valid = running && word_out.valid;
  assign dp_wr    = running && word_out.wr;
  assign dp_tag   = running ? word_out.tag : '0;
  assign busy     = rst || (state_q == ST_FLUSH) || (inflight_q != '0);

  // NOTE: every variable gets its default before any branch, so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    since_d     = since_q;
    last_dir_d  = last_dir_q;
    rr_pref_d   = rr_pref_q;
    inflight_d  = inflight_q;

    case (state_q)
      ST_FLUSH: begin
        if (flush_cnt_q > FLUSH_W'(1)) begin
          flush_cnt_d = flush_cnt_q - FLUSH_W'(1);
        end else begin
          flush_cnt_d = '0;
          state_d     = ST_RUN;
        end
      end
      default: ;
    endcase

    if (grant) begin
      since_d    = SINCE_W'(1);
      last_dir_d = gnt_dir;
    end else if (since_q != TTURN_C) begin
      since_d = since_q + SINCE_W'(1);
    end

    // Round-robin only advances when it actually resolved a conflict.
    if (rd_ok && wr_ok) begin
      rr_pref_d = (rr_pref_q == DIR_WR) ? DIR_RD : DIR_WR;
    end

    case ({grant, dp_valid})
      2'b10:   inflight_d = inflight_q + INFL_W'(1);
      2'b01:   inflight_d = inflight_q - INFL_W'(1);
      default: ;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FLUSH;
      flush_cnt_q <= FLUSH_W'(PIPE_LEN);
      since_q     <= TTURN_C;
      last_dir_q  <= DIR_RD;
      rr_pref_q   <= DIR_WR;
      inflight_q  <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      since_q     <= since_d;
      last_dir_q  <= last_dir_d;
      rr_pref_q   <= rr_pref_d;
      inflight_q  <= inflight_d;
    end
  end

`ifdef DDR3_DQ_SCHED_STATS_EN
  logic [15:0] stat_rd_q, stat_wr_q, stat_turn_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_rd_q   <= '0;
      stat_wr_q   <= '0;
      stat_turn_q <= '0;
    end else begin
      if (rd_ready && (stat_rd_q != 16'hFFFF)) stat_rd_q <= stat_rd_q + 16'd1;
      if (wr_ready && (stat_wr_q != 16'hFFFF)) stat_wr_q <= stat_wr_q + 16'd1;
      if (grant && (gnt_dir != last_dir_q) && (stat_turn_q != 16'hFFFF)) begin
        stat_turn_q <= stat_turn_q + 16'd1;
      end
    end
  end

  assign stat_rd   = stat_rd_q;
  assign stat_wr   = stat_wr_q;
  assign stat_turn = stat_turn_q;
`endif

endmodule
